registers_writeback: RTL and testbench
======================================

// Module: registers_writeback
// PURPOSE
//  Write-side initiator for the register file: drives its rd/rd_wd/rd_we write port.
//  Merges single-cycle ALU results with in-order load results returning from the PSRAM cache.
//  Keeps a FIFO of rd indices for loads in flight.
//  Exposes a scoreboard so the core stalls on rs1/rs2 reads of registers not yet written.
// PARAMETERS
//  ADDR_WIDTH  5   register index width (2**ADDR_WIDTH registers)
//  WIDTH       32  register data width
//  DEPTH       4   max loads in flight (power of two, >=2)
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst             in   1           synchronous reset, active-high
//  alu_valid       in   1           ALU result offered
//  alu_ready       out  1           ALU result accepted this cycle
//  alu_rd          in   ADDR_WIDTH  ALU destination register
//  alu_data        in   WIDTH       ALU result
//  ld_issue_valid  in   1           core issues a load targeting ld_issue_rd
//  ld_issue_ready  out  1           load slot available (FIFO not full)
//  ld_issue_rd     in   ADDR_WIDTH  load destination register
//  ld_resp_valid   in   1           cache returns oldest load's data; never stalled
//  ld_resp_data    in   WIDTH       load data
//  rs1, rs2        in   ADDR_WIDTH  source indices being read by the core
//  rs1_busy        out  1           rs1 has a pending load (combinational)
//  rs2_busy        out  1           rs2 has a pending load (combinational)
//  rd              out  ADDR_WIDTH  register file write index (registered)
//  rd_wd           out  WIDTH       register file write data (registered)
//  rd_we           out  1           register file write enable (registered)
//  pending         out  $clog2(DEPTH)+1  loads in flight
//  ld_err          out  1           sticky: response arrived with no load pending
// BEHAVIOUR
//  Reset: FIFO emptied, pending=0, rd=0, rd_wd=0, rd_we=0, ld_err=0 (abandons in-flight loads).
//  Handshakes: transfer on valid&&ready; ready never depends on its own valid.
//  Latency: accepted result appears on rd/rd_wd with rd_we=1 exactly 1 cycle later.
//   RF commits on the following edge.
//  Arbitration: load response has priority.
//   alu_ready = !ld_resp_valid; same-cycle ALU result stalls one cycle.
//  Load issue: push ld_issue_rd when ld_issue_valid && !full.
//   ld_issue_ready = !full; no pass-through while full, even if a response pops same cycle.
//  Load response: pops FIFO head; write {head_rd, ld_resp_data}.
//   Response on empty FIFO: no write, no pop; ld_err<=1 until rst.
//  Simultaneous issue+response: push and pop both happen; pending unchanged.
//  Register 0: writes to index 0 (ALU or load) emit rd_we=0; load still pops.
//   rs*_busy is always 0 for index 0.
//  Scoreboard: rsN_busy = OR over valid FIFO entries of (entry_rd == rsN).
//   Entry popped this cycle still counts busy; RF value valid after rd_we edge.
//   No forwarding: core stalls one extra cycle.
//  Same rd may be pending in several entries; busy clears only after the last one pops.
//  WAW: ALU write to a busy rd is accepted; the later load overwrites it.
//   The core must stall such issue via the busy outputs.
//  Pointers: head/tail are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   full = (MSBs differ && rest equal).
//  rd_we deasserts the cycle after no transfer; rd/rd_wd hold their last value.
// TESTING
//  1: reset; alu_valid, rd=5, data=0xDEADBEEF -> next cycle rd=5, rd_wd=DEADBEEF, rd_we=1; then rd_we=0.
//  2: issue loads to x3,x7,x3,x9 -> pending=4, ld_issue_ready=0, rs1=3 busy.
//     Responses A,B,C,D -> writes x3=A,x7=B,x3=C,x9=D; x3 busy until 3rd response.
//  3: ld_resp_valid and alu_valid same cycle -> alu_ready=0, load written first, ALU written next cycle.
//  4: FIFO full + same-cycle issue/response -> issue refused, pending 3.
//     With pending=2, issue+response -> pending stays 2.
//  5: load to x0 then response -> pending 1->0, rd_we=0, rs1=0 never busy.
//     Response with pending=0 -> ld_err=1, no write.
//  6: rst asserted with 3 loads pending -> next cycle pending=0, busy=0, rd_we=0, ld_err=0.

Source files
------------

// File: rtl/registers_writeback.sv
// registers_writeback: register-file write-port initiator.
// Merges single-cycle ALU results with in-order load responses, keeps a FIFO
// of destination indices for loads in flight, and reports which source
// registers still await a load so the core can stall.
module registers_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_WIDTH-1:0]      alu_rd,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic                       ld_issue_valid,
    output logic                       ld_issue_ready,
    input  logic [ADDR_WIDTH-1:0]      ld_issue_rd,
    input  logic                       ld_resp_valid,
    input  logic [WIDTH-1:0]           ld_resp_data,
    input  logic [ADDR_WIDTH-1:0]      rs1,
    input  logic [ADDR_WIDTH-1:0]      rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [ADDR_WIDTH-1:0]      rd,
    output logic [WIDTH-1:0]           rd_wd,
    output logic                       rd_we,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       ld_err
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    logic [ADDR_WIDTH-1:0] fifo_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]      rd_wd_q, rd_wd_d;
    logic                  rd_we_q, rd_we_d;
    logic                  ld_err_q, ld_err_d;

    logic                  full, empty, push, pop, alu_fire;
    logic [PW-1:0]         count;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DEPTH-1:0]      match1, match2;

    assign empty    = (head_q == tail_q);
    assign full     = (head_q[PW-1] != tail_q[PW-1]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign count    = tail_q - head_q;
    assign head_rd  = fifo_q[head_q[IW-1:0]];

    // Ready signals depend only on state and the competing request, never on their own valid.
    assign ld_issue_ready = !full;
    assign alu_ready      = !ld_resp_valid;

    assign push     = ld_issue_valid && !full;
    assign pop      = ld_resp_valid && !empty;
    assign alu_fire = alu_valid && !ld_resp_valid;

    // Per-slot scoreboard match: a slot is live if it lies within [head, head+count).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam int unsigned SLOT = gi;
            logic [IW-1:0] ofs;
            logic          live;
            assign ofs         = IW'(SLOT) - head_q[IW-1:0];
            assign live        = ({1'b0, ofs} < count);
            assign match1[gi]  = live && (fifo_q[gi] == rs1);
            assign match2[gi]  = live && (fifo_q[gi] == rs2);
        end
    endgenerate

    // x0 is hardwired, so it is never reported as awaiting a load.
    assign rs1_busy = (|match1) && (rs1 != '0);
    assign rs2_busy = (|match2) && (rs2 != '0);

    // Next-state: pointers, write port (load response wins over ALU), sticky error.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        rd_d     = rd_q;
        rd_wd_d  = rd_wd_q;
        rd_we_d  = 1'b0;
        ld_err_d = ld_err_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d  = head_q + 1'b1;
            rd_d    = head_rd;
            rd_wd_d = ld_resp_data;
            rd_we_d = (head_rd != '0);
        end else if (alu_fire) begin
            rd_d    = alu_rd;
            rd_wd_d = alu_data;
            rd_we_d = (alu_rd != '0);
        end
        if (ld_resp_valid && empty) begin
            ld_err_d = 1'b1;
        end
    end

    // FIFO storage of load destinations; contents are don't-care outside [head, tail).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q[IW-1:0]] <= ld_issue_rd;
        end
    end

    // State registers with synchronous reset; reset abandons any in-flight loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            rd_q     <= '0;
            rd_wd_q  <= '0;
            rd_we_q  <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            rd_q     <= rd_d;
            rd_wd_q  <= rd_wd_d;
            rd_we_q  <= rd_we_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign rd      = rd_q;
    assign rd_wd   = rd_wd_q;
    assign rd_we   = rd_we_q;
    assign pending = count;
    assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_registers_writeback.sv
// Bench for registers_writeback: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_registers_writeback;
    localparam int AW    = 5;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [W-1:0]  alu_data = '0;
    logic          ld_issue_valid = 1'b0;
    logic          ld_issue_ready;
    logic [AW-1:0] ld_issue_rd = '0;
    logic          ld_resp_valid = 1'b0;
    logic [W-1:0]  ld_resp_data = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          rs1_busy, rs2_busy;
    logic [AW-1:0] rd;
    logic [W-1:0]  rd_wd;
    logic          rd_we;
    logic [$clog2(DEPTH):0] pending;
    logic          ld_err;

    int checks = 0;
    int errors = 0;

    // Reference model: destinations of loads in flight, oldest first.
    logic [AW-1:0] mq[$];
    logic [AW-1:0] m_rd;
    logic [W-1:0]  m_wd;
    logic          m_we;
    logic          m_err;

    registers_writeback #(.ADDR_WIDTH(AW), .WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .rd_wd(rd_wd), .rd_we(rd_we), .pending(pending), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic busy_of(input logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        foreach (mq[i]) if (mq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_regs();
        chk("rd_we", 32'(rd_we), 32'(m_we));
        if (m_we) begin
            chk("rd", 32'(rd), 32'(m_rd));
            chk("rd_wd", rd_wd, m_wd);
        end
        chk("pending", 32'(pending), mq.size());
        chk("ld_err", 32'(ld_err), 32'(m_err));
    endtask

    task automatic do_reset(input logic [AW-1:0] r1);
        rst = 1'b1; alu_valid = 1'b0; ld_issue_valid = 1'b0; ld_resp_valid = 1'b0; rs1 = r1; rs2 = r1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); m_rd = '0; m_wd = '0; m_we = 1'b0; m_err = 1'b0;
        chk("rst_rd", 32'(rd), 0);
        chk("rst_rd_wd", rd_wd, 0);
        chk("rst_rd_we", 32'(rd_we), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ld_err", 32'(ld_err), 0);
        chk("rst_rs1_busy", 32'(rs1_busy), 0);
        $display("reset rs1=%0d pending=%0d rd_we=%0b ld_err=%0b", r1, pending, rd_we, ld_err);
    endtask

    // One clock of stimulus: check combinational outputs, then the registered result.
    task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic [W-1:0] ad,
                       input logic iv, input logic [AW-1:0] ird,
                       input logic rv, input logic [W-1:0] rdat,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        logic push, pop;
        logic [AW-1:0] h;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_issue_valid = iv; ld_issue_rd = ird;
        ld_resp_valid = rv; ld_resp_data = rdat;
        rs1 = r1; rs2 = r2;
        @(negedge clk);
        chk("alu_ready", 32'(alu_ready), 32'(!rv));
        chk("ld_issue_ready", 32'(ld_issue_ready), 32'(mq.size() < DEPTH));
        chk("rs1_busy", 32'(rs1_busy), 32'(busy_of(r1)));
        chk("rs2_busy", 32'(rs2_busy), 32'(busy_of(r2)));
        push = iv && (mq.size() < DEPTH);
        pop  = rv && (mq.size() > 0);
        if (rv && mq.size() == 0) m_err = 1'b1;
        m_we = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            m_we = (h != '0);
            if (m_we) begin m_rd = h; m_wd = rdat; end
        end else if (av && !rv) begin
            m_we = (ard != '0);
            if (m_we) begin m_rd = ard; m_wd = ad; end
        end
        if (push) mq.push_back(ird);
        @(posedge clk); #1;
        alu_valid = 1'b0; ld_issue_valid = 1'b0; ld_resp_valid = 1'b0;
        check_regs();
        $display("cyc alu=%0b/%0d iss=%0b/%0d resp=%0b -> rd_we=%0b rd=%0d rd_wd=%08h pending=%0d err=%0b",
                 av, ard, iv, ird, rv, rd_we, rd, rd_wd, pending, ld_err);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd3, 5'd7);
    endtask

    initial begin
        // 1: ALU write then idle
        do_reset(5'd0);
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, 5'd0, 5'd0);
        idle();
        chk("hold_rd", 32'(rd), 5);
        chk("hold_rd_wd", rd_wd, 32'hDEADBEEF);

        // 2: four loads, in-order responses, x3 busy until its last entry pops
        cyc(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, 5'd3, 5'd9);
        cyc(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, 5'd3, 5'd9);
        cyc(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, 5'd3, 5'd9);
        cyc(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, 5'd3, 5'd9);
        chk("full_pending", 32'(pending), 4);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hAAAA0001, 5'd3, 5'd7);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hBBBB0002, 5'd3, 5'd7);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hCCCC0003, 5'd3, 5'd9);
        chk("x3_free", 32'(rs1_busy), 0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hDDDD0004, 5'd3, 5'd9);

        // 3: response and ALU collide; ALU retried next cycle
        cyc(1'b0, '0, '0, 1'b1, 5'd10, 1'b0, '0, 5'd10, 5'd11);
        cyc(1'b1, 5'd11, 32'h11111111, 1'b0, '0, 1'b1, 32'h22222222, 5'd10, 5'd11);
        chk("first_is_load", 32'(rd), 10);
        cyc(1'b1, 5'd11, 32'h11111111, 1'b0, '0, 1'b0, '0, 5'd10, 5'd11);
        chk("then_alu", 32'(rd), 11);

        // 4: full FIFO refuses issue even with same-cycle pop; issue+pop keeps pending
        cyc(1'b0, '0, '0, 1'b1, 5'd1, 1'b0, '0, 5'd1, 5'd6);
        cyc(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, '0, 5'd1, 5'd6);
        cyc(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0, 5'd1, 5'd6);
        cyc(1'b0, '0, '0, 1'b1, 5'd6, 1'b0, '0, 5'd1, 5'd6);
        cyc(1'b0, '0, '0, 1'b1, 5'd8, 1'b1, 32'h0000A001, 5'd8, 5'd6);
        chk("refused_pending", 32'(pending), 3);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h0000A002, 5'd8, 5'd4);
        cyc(1'b0, '0, '0, 1'b1, 5'd12, 1'b1, 32'h0000A003, 5'd12, 5'd6);
        chk("swap_pending", 32'(pending), 2);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h0000A004, 5'd12, 5'd6);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h0000A005, 5'd12, 5'd6);

        // 5: load to x0, then a stray response sets ld_err
        cyc(1'b0, '0, '0, 1'b1, 5'd0, 1'b0, '0, 5'd0, 5'd0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h12345678, 5'd0, 5'd0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h87654321, 5'd0, 5'd0);
        chk("err_set", 32'(ld_err), 1);

        // 6: reset with three loads pending
        cyc(1'b0, '0, '0, 1'b1, 5'd13, 1'b0, '0, 5'd13, 5'd0);
        cyc(1'b0, '0, '0, 1'b1, 5'd14, 1'b0, '0, 5'd13, 5'd0);
        cyc(1'b0, '0, '0, 1'b1, 5'd15, 1'b0, '0, 5'd13, 5'd0);
        do_reset(5'd13);

        // Random traffic with a small register range to provoke collisions
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0), $urandom(),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
